// File: rtl/writeback_unit_if.sv
// Bundle between issue/execute (master) and the integer register-file write port producer (slave).
// Both handshakes are valid/ready: a transfer happens on a rising edge where the sender's valid and the receiver's ready are both high.
interface writeback_unit_if #(
    parameter int XLEN = 32
);
    logic            rsv_valid;
    logic [4:0]      rsv_rd;
    logic            rsv_ready;
    logic [4:0]      q_rs0;
    logic [4:0]      q_rs1;
    logic            q_busy0;
    logic            q_busy1;
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            alu_stall;
    logic            lsu_valid;
    logic            lsu_ready;
    logic [4:0]      lsu_rd;
    logic [XLEN-1:0] lsu_data;
    logic [4:0]      wr;
    logic [XLEN-1:0] wr_data;

    modport master (
        output rsv_valid, rsv_rd, q_rs0, q_rs1, alu_valid, alu_rd, alu_data,
               lsu_valid, lsu_rd, lsu_data,
        input  rsv_ready, q_busy0, q_busy1, alu_stall, lsu_ready, wr, wr_data
    );

    modport slave (
        input  rsv_valid, rsv_rd, q_rs0, q_rs1, alu_valid, alu_rd, alu_data,
               lsu_valid, lsu_rd, lsu_data,
        output rsv_ready, q_busy0, q_busy1, alu_stall, lsu_ready, wr, wr_data
    );
endinterface

// File: rtl/writeback_unit.sv
// Merges ALU and queued long-latency results into one registered register-file write per cycle,
// and tracks outstanding long-latency destinations in a pending-write scoreboard.
module writeback_unit #(
    parameter int QUEUE_DEPTH = 4,
    parameter int XLEN        = 32
) (
    input logic             clk,
    input logic             rst_n,
    writeback_unit_if.slave bus
);
    localparam int           AW    = $clog2(QUEUE_DEPTH);
    localparam logic [AW:0]  DEPTH = (AW + 1)'(QUEUE_DEPTH);

    logic [4:0]      q_rd   [QUEUE_DEPTH];
    logic [XLEN-1:0] q_data [QUEUE_DEPTH];
    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;
    logic [AW:0]     count;
    logic [31:1]     busy_q;
    logic [31:0]     busy;
    logic [31:1]     set_mask;
    logic [31:1]     clr_mask;
    logic [4:0]      head_rd;
    logic [4:0]      wr_q;
    logic [XLEN-1:0] wr_data_q;
    logic            full;
    logic            empty;
    logic            rsv_ok;
    logic            rsv_take;
    logic            alu_take;
    logic            pop;
    logic            push;

    assign busy    = {busy_q, 1'b0};
    assign full    = (count == DEPTH);
    assign empty   = (count == '0);
    assign head_rd = q_rd[head];

    assign rsv_ok   = (bus.rsv_rd == 5'd0) || !busy[bus.rsv_rd];
    assign rsv_take = bus.rsv_valid && rsv_ok && (bus.rsv_rd != 5'd0);
    // A full queue blocks both inputs so the head is guaranteed to drain next edge.
    assign alu_take = !full && bus.alu_valid && (bus.alu_rd != 5'd0);
    assign pop      = !alu_take && !empty;
    assign push     = bus.lsu_valid && !full && (bus.lsu_rd != 5'd0);

    assign bus.rsv_ready = rsv_ok;
    assign bus.q_busy0   = busy[bus.q_rs0];
    assign bus.q_busy1   = busy[bus.q_rs1];
    assign bus.alu_stall = full;
    assign bus.lsu_ready = !full;
    assign bus.wr        = wr_q;
    assign bus.wr_data   = wr_data_q;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        for (int i = 1; i < 32; i++) begin
            set_mask[i] = rsv_take && (bus.rsv_rd == 5'(i));
            clr_mask[i] = pop && (head_rd == 5'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_rd[tail]   <= bus.lsu_rd;
            q_data[tail] <= bus.lsu_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            busy_q    <= '0;
            wr_q      <= '0;
            wr_data_q <= '0;
        end else begin
            if (push) tail <= tail + AW'(1);
            if (pop)  head <= head + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
            // Set and clear never target the same bit: a busy rd refuses reservation.
            busy_q <= (busy_q & ~clr_mask) | set_mask;
            if (alu_take) begin
                wr_q      <= bus.alu_rd;
                wr_data_q <= bus.alu_data;
            end else if (pop) begin
                wr_q      <= head_rd;
                wr_data_q <= q_data[head];
            end else begin
                wr_q      <= 5'd0;
            end
        end
    end

    a_alu_not_stalled: assert property (@(posedge clk) disable iff (!rst_n)
        bus.alu_valid |-> !full);
    a_alu_rd_not_busy: assert property (@(posedge clk) disable iff (!rst_n)
        bus.alu_valid |-> !busy[bus.alu_rd]);
    a_lsu_rd_reserved: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.lsu_valid && bus.lsu_rd != 5'd0) |-> busy[bus.lsu_rd]);
endmodule
